// File: rtl/trigger_queue_pkg.sv
// Shared widths, default depth and slot payload type for the trigger readout queue.
// Optional build macro: TRIGGER_QUEUE_EVNUM_EN adds a 16-bit event number to each slot.
package trigger_queue_pkg;

  localparam int L4_W          = 4;
  localparam int INFO_W        = 32;
  localparam int DELAY_W       = 9;
  localparam int DROP_W        = 8;
  localparam int EVNUM_W       = 16;
  localparam int DEFAULT_DEPTH = 8;

  typedef struct packed {
    logic [L4_W-1:0]    l4;
    logic [INFO_W-1:0]  info;
`ifdef TRIGGER_QUEUE_EVNUM_EN
    logic [EVNUM_W-1:0] evnum;
`endif
  } slot_payload_t;

endpackage

// File: rtl/trigger_queue_slot.sv
// One queue slot: payload register plus a saturating hold-time countdown.
// The slot is ripe once its remaining count has reached zero.
// Optional build macro: TRIGGER_QUEUE_EVNUM_EN (payload width follows the package struct).
module trigger_queue_slot
  import trigger_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  slot_payload_t        load_payload,
  input  logic [DELAY_W-1:0]   load_delay,
  output slot_payload_t        payload,
  output logic                 ripe
);

  logic [DELAY_W-1:0] remain;

  // Countdown: reload on write, otherwise step down once per cycle and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain <= '0;
    end else if (load) begin
      remain <= load_delay;
    end else if (remain != '0) begin
      remain <= remain - DELAY_W'(1);
    end
  end

  // Payload storage is pure data and only changes when the slot is written.
  always_ff @(posedge clk) begin
    if (load) begin
      payload <= load_payload;
    end
  end

  assign ripe = (remain == '0);

endmodule

// File: rtl/trigger_readout_queue.sv
// Trigger readout queue: holds each accepted trigger for its requested delay and
// presents entries in strict arrival order over a registered valid/ready handshake.
// A full queue drops new triggers, counting them instead of stalling the trigger path.
// Optional build macro: TRIGGER_QUEUE_EVNUM_EN adds rdout_evnum_o and an event counter.
module trigger_readout_queue
  import trigger_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     fclk_i,
  input  logic                     rst_n_i,
  input  logic                     trig_i,
  input  logic [L4_W-1:0]          trig_l4_i,
  input  logic [DELAY_W-1:0]       trig_delay_i,
  input  logic [INFO_W-1:0]        trig_info_i,
  input  logic                     disable_i,
  output logic                     rdout_valid_o,
  input  logic                     rdout_ready_i,
  output logic [L4_W-1:0]          rdout_l4_o,
  output logic [INFO_W-1:0]        rdout_info_o,
  input  logic                     clr_ovf_i,
  output logic                     ovf_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef TRIGGER_QUEUE_EVNUM_EN
  ,
  output logic [EVNUM_W-1:0]       rdout_evnum_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head_next;
  logic [CNT_W-1:0] remain_cnt;
  logic             trig_ok;
  logic             push;
  logic             pop;
  logic             drop;
  logic             valid_next;
  logic [DEPTH-1:0] slot_load;
  logic [DEPTH-1:0] slot_ripe;
  slot_payload_t    slot_payload [DEPTH];
  slot_payload_t    wr_payload;

`ifdef TRIGGER_QUEUE_EVNUM_EN
  logic [EVNUM_W-1:0] evnum_cnt;
`endif

  // Handshake and queue control: a pop frees the head slot so a full queue can still accept.
  always_comb begin
    trig_ok    = trig_i & ~disable_i;
    pop        = rdout_valid_o & rdout_ready_i;
    push       = trig_ok & ((count != CNT_W'(DEPTH)) | pop);
    drop       = trig_ok & (count == CNT_W'(DEPTH)) & ~pop;
    head_next  = pop ? head + PTR_W'(1) : head;
    // Entries that were already resident and remain after this pop; a slot being
    // written this cycle must not be presented from its stale ripe state.
    remain_cnt = count - CNT_W'(pop);
    valid_next = (remain_cnt != '0) & slot_ripe[head_next];
    wr_payload.l4   = trig_l4_i;
    wr_payload.info = trig_info_i;
`ifdef TRIGGER_QUEUE_EVNUM_EN
    wr_payload.evnum = evnum_cnt;
`endif
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      assign slot_load[i] = push & (tail == PTR_W'(i));
      trigger_queue_slot u_slot (
        .clk          (fclk_i),
        .rst_n        (rst_n_i),
        .load         (slot_load[i]),
        .load_payload (wr_payload),
        .load_delay   (trig_delay_i),
        .payload      (slot_payload[i]),
        .ripe         (slot_ripe[i])
      );
    end
  endgenerate

  // Head/tail pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Overflow tracking: a drop in the same cycle as a clear wins and restarts the count at 1.
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      ovf_o      <= 1'b1;
      if (clr_ovf_i)                drop_cnt_o <= DROP_W'(1);
      else if (drop_cnt_o != '1)    drop_cnt_o <= drop_cnt_o + DROP_W'(1);
    end else if (clr_ovf_i) begin
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
    end
  end

  // Registered readout: looks past this cycle's pop so a ripe next head streams back-to-back.
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdout_valid_o <= 1'b0;
      rdout_l4_o    <= '0;
      rdout_info_o  <= '0;
`ifdef TRIGGER_QUEUE_EVNUM_EN
      rdout_evnum_o <= '0;
`endif
    end else begin
      rdout_valid_o <= valid_next;
      if (valid_next) begin
        rdout_l4_o    <= slot_payload[head_next].l4;
        rdout_info_o  <= slot_payload[head_next].info;
`ifdef TRIGGER_QUEUE_EVNUM_EN
        rdout_evnum_o <= slot_payload[head_next].evnum;
`endif
      end
    end
  end

`ifdef TRIGGER_QUEUE_EVNUM_EN
  // Event number advances on every accepted trigger, never on drops, and wraps at 16 bits.
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      evnum_cnt <= '0;
    end else if (push) begin
      evnum_cnt <= evnum_cnt + EVNUM_W'(1);
    end
  end
`endif

  assign count_o = count;

endmodule

// File: tb/tb_trigger_readout_queue.sv
// Directed bench for trigger_readout_queue (DEPTH=8): latency, ordering, overflow,
// clear/drop collision, disable and asynchronous reset.
// Optional build macro: TRIGGER_QUEUE_EVNUM_EN enables the event-number check.
module tb_trigger_readout_queue;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [3:0]  trig_l4;
  logic [8:0]  trig_delay;
  logic [31:0] trig_info;
  logic        dis;
  logic        valid;
  logic        ready;
  logic [3:0]  l4;
  logic [31:0] info;
  logic        clr_ovf;
  logic        ovf;
  logic [7:0]  drop_cnt;
  logic [3:0]  count;
`ifdef TRIGGER_QUEUE_EVNUM_EN
  logic [15:0] evnum;
`endif

  int total = 0;
  int bad   = 0;

  trigger_readout_queue #(.DEPTH(8)) dut (
    .fclk_i        (fclk),
    .rst_n_i       (rst_n),
    .trig_i        (trig),
    .trig_l4_i     (trig_l4),
    .trig_delay_i  (trig_delay),
    .trig_info_i   (trig_info),
    .disable_i     (dis),
    .rdout_valid_o (valid),
    .rdout_ready_i (ready),
    .rdout_l4_o    (l4),
    .rdout_info_o  (info),
    .clr_ovf_i     (clr_ovf),
    .ovf_o         (ovf),
    .drop_cnt_o    (drop_cnt),
    .count_o       (count)
`ifdef TRIGGER_QUEUE_EVNUM_EN
    ,
    .rdout_evnum_o (evnum)
`endif
  );

  always #5 fclk = ~fclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  // Present one trigger strobe across exactly one rising edge.
  task automatic send(input logic [3:0] l, input logic [8:0] d, input logic [31:0] w);
    trig       = 1'b1;
    trig_l4    = l;
    trig_delay = d;
    trig_info  = w;
    tick();
    trig       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; trig = 1'b0; trig_l4 = '0; trig_delay = '0; trig_info = '0;
    dis = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_info",  info, 32'd0);
    check("rst_l4",    32'(l4), 32'd0);
    check("rst_ovf",   32'(ovf), 32'd0);
    check("rst_drop",  32'(drop_cnt), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Single trigger, delay 5: valid only after edge N+6, then popped.
    ready = 1'b1;
    send(4'h3, 9'd5, 32'hDEADBEEF);
    check("t1_count_after_push", 32'(count), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t1_early_valid", 32'(valid), 32'd0);
    end
    tick();
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_info",  info, 32'hDEADBEEF);
    check("t1_l4",    32'(l4), 32'd3);
    tick();
    check("t1_valid_once", 32'(valid), 32'd0);
    check("t1_count_zero", 32'(count), 32'd0);

    // Unripe head blocks a ripe follower: releases after N+21 and N+22.
    send(4'h1, 9'd20, 32'h0000_0001);
    send(4'h2, 9'd0,  32'h0000_0002);
    for (int k = 2; k <= 20; k++) begin
      tick();
      check("t2_blocked", 32'(valid), 32'd0);
    end
    tick();
    check("t2_first_valid", 32'(valid), 32'd1);
    check("t2_first_info",  info, 32'h1);
    tick();
    check("t2_second_valid", 32'(valid), 32'd1);
    check("t2_second_info",  info, 32'h2);
    tick();
    check("t2_done_valid", 32'(valid), 32'd0);
    check("t2_done_count", 32'(count), 32'd0);

    // Overflow: 10 triggers into 8 slots with the scheduler stalled.
    ready = 1'b0;
    for (int i = 0; i < 10; i++) send(4'h4, 9'd0, 32'h100 + 32'(i));
    check("t3_count", 32'(count), 32'd8);
    check("t3_ovf",   32'(ovf), 32'd1);
    check("t3_drop",  32'(drop_cnt), 32'd2);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_drain_valid", 32'(valid), 32'd1);
      check("t3_drain_info",  info, 32'h100 + 32'(i));
      tick();
    end
    check("t3_empty_valid", 32'(valid), 32'd0);
    check("t3_empty_count", 32'(count), 32'd0);

    // Clear, refill, push+pop on a full queue, then clear colliding with a drop.
    ready = 1'b0;
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t4_clr_ovf",  32'(ovf), 32'd0);
    check("t4_clr_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) send(4'h5, 9'd0, 32'h200 + 32'(i));
    check("t4_full", 32'(count), 32'd8);
    ready = 1'b1;
    send(4'h6, 9'd0, 32'h2FF);
    check("t4_pushpop_count", 32'(count), 32'd8);
    check("t4_pushpop_drop",  32'(drop_cnt), 32'd0);
    check("t4_pushpop_ovf",   32'(ovf), 32'd0);
    check("t4_pushpop_info",  info, 32'h201);
    ready = 1'b0;
    clr_ovf = 1'b1;
    send(4'h6, 9'd0, 32'h3FF);
    clr_ovf = 1'b0;
    check("t4_clrdrop_cnt", 32'(drop_cnt), 32'd1);
    check("t4_clrdrop_ovf", 32'(ovf), 32'd1);
    check("t4_clrdrop_count", 32'(count), 32'd8);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_order_valid", 32'(valid), 32'd1);
      check("t4_order_info",  info, (i < 7) ? 32'h201 + 32'(i) : 32'h2FF);
      tick();
    end
    check("t4_empty_count", 32'(count), 32'd0);

    // Disable ignores strobes but a queued entry still drains.
    ready = 1'b0;
    send(4'h7, 9'd3, 32'h555);
    dis = 1'b1;
    for (int i = 0; i < 3; i++) send(4'h8, 9'd0, 32'h666);
    check("t5_count", 32'(count), 32'd1);
    check("t5_drop",  32'(drop_cnt), 32'd1);
    ready = 1'b1;
    tick();
    check("t5_valid", 32'(valid), 32'd1);
    check("t5_info",  info, 32'h555);
    tick();
    check("t5_drained", 32'(count), 32'd0);
    dis = 1'b0;

    // Asynchronous reset while entries are presented and stalled.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'h9, 9'd0, 32'h700 + 32'(i));
    check("t6_pre_count", 32'(count), 32'd4);
    check("t6_pre_valid", 32'(valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_info",  info, 32'd0);
    check("t6_rst_l4",    32'(l4), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_ovf",   32'(ovf), 32'd0);
    check("t6_rst_drop",  32'(drop_cnt), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    ready = 1'b1;
    send(4'hA, 9'd2, 32'h900);
    tick();
    check("t6_wait1", 32'(valid), 32'd0);
    tick();
    check("t6_wait2", 32'(valid), 32'd0);
    tick();
    check("t6_valid", 32'(valid), 32'd1);
    check("t6_info",  info, 32'h900);
    check("t6_l4",    32'(l4), 32'hA);
`ifdef TRIGGER_QUEUE_EVNUM_EN
    check("t6_evnum", 32'(evnum), 32'd0);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
